time_entry_keypad: RTL and testbench

//  Input-side counterpart of the display path: scans a 4x4 matrix keypad and collects an HH:MM entry digit by digit.

---
 rtl/clock_pkg.sv | 67 ++++++
 rtl/keypad_scan.sv | 139 +++++++++++++
 rtl/time_entry_keypad.sv | 182 ++++++++++++++++++
 tb/tb_time_entry_keypad.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared key codes, digit limits and FSM encoding for the time entry keypad.
// KEYPAD_ABORT_EN (optional): '*' aborts an entry session.
package clock_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [3:0] MAX_HT      = 4'd2;
    localparam logic [3:0] MAX_HO      = 4'd9;
    localparam logic [3:0] MAX_HO_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MT      = 4'd5;
    localparam logic [3:0] MAX_MO      = 4'd9;

    localparam logic [2:0] TW_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_DECODE,
        ST_WAIT_REL,
        ST_COMMIT
    } state_e;

    function automatic logic [3:0] key_map(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] k;
        k = 4'd0;
        case ({r, c})
            4'h0: k = 4'd1;
            4'h1: k = 4'd2;
            4'h2: k = 4'd3;
            4'h3: k = KEY_A;
            4'h4: k = 4'd4;
            4'h5: k = 4'd5;
            4'h6: k = 4'd6;
            4'h7: k = KEY_B;
            4'h8: k = 4'd7;
            4'h9: k = 4'd8;
            4'hA: k = 4'd9;
            4'hB: k = KEY_C;
            4'hC: k = KEY_STAR;
            4'hD: k = 4'd0;
            4'hE: k = KEY_HASH;
            4'hF: k = KEY_D;
        endcase
        return k;
    endfunction

    // Splits a 0..59 value into {tens, ones} without a divider.
    function automatic logic [7:0] split_dec(input logic [5:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            if ({1'b0, v} >= 7'(10 * i))
                tens = 4'(i);
        end
        rem = {1'b0, v} - 7'(10 * tens);
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with scan-tick divider, press debounce
// and release detection on the frozen column.
module keypad_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int DB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_hit,
    output logic       key_lost,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       released
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DB_TICKS + 1);

    typedef enum logic [1:0] {
        PH_ROT,
        PH_DB,
        PH_REL
    } phase_e;

    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;

    logic          tick;
    logic          any_low;
    logic [1:0]    low_idx;

    always_comb begin
        any_low = ~&row_sync_q;
        if (!row_sync_q[0])
            low_idx = 2'd0;
        else if (!row_sync_q[1])
            low_idx = 2'd1;
        else if (!row_sync_q[2])
            low_idx = 2'd2;
        else
            low_idx = 2'd3;
    end

    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
        div_d      = div_q;
        cidx_d     = cidx_q;
        ridx_d     = ridx_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        key_hit    = 1'b0;
        key_lost   = 1'b0;
        key_valid  = 1'b0;
        released   = 1'b0;
        tick       = (div_q == DW'(SCAN_DIV - 1));
        if (!en) begin
            div_d   = '0;
            cidx_d  = 2'd0;
            cnt_d   = '0;
            phase_d = PH_ROT;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                unique case (phase_q)
                    PH_ROT: begin
                        if (any_low) begin
                            ridx_d  = low_idx;
                            cnt_d   = '0;
                            phase_d = PH_DB;
                            key_hit = 1'b1;
                        end else begin
                            cidx_d = cidx_q + 2'd1;
                        end
                    end
                    PH_DB: begin
                        if (!any_low || low_idx != ridx_q) begin
                            phase_d  = PH_ROT;
                            key_lost = 1'b1;
                        end else if (cnt_q == CW'(DB_TICKS - 1)) begin
                            cnt_d     = '0;
                            phase_d   = PH_REL;
                            key_valid = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PH_REL: begin
                        if (any_low) begin
                            cnt_d = '0;
                        end else if (cnt_q == CW'(DB_TICKS - 1)) begin
                            cnt_d    = '0;
                            phase_d  = PH_ROT;
                            released = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: phase_d = PH_ROT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            div_q      <= '0;
            cidx_q     <= 2'd0;
            ridx_q     <= 2'd0;
            cnt_q      <= '0;
            phase_q    <= PH_ROT;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            div_q      <= div_d;
            cidx_q     <= cidx_d;
            ridx_q     <= ridx_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Column and row index stay frozen from detection until release.
    assign col      = en ? ~(4'b0001 << cidx_q) : 4'hF;
    assign key_code = key_map(ridx_q, cidx_q);

endmodule

// File: rtl/time_entry_keypad.sv
// Keypad HH:MM entry: staging digits, validation and the session FSM.
// KEYPAD_ABORT_EN: when defined, '*' abandons the session unchanged.
module time_entry_keypad
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int DB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       next,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [5:0] key_hour,
    output logic [5:0] key_minute,
    output logic [2:0] twinkle,
    output logic       set_time,
    output logic       busy
);

    state_e          state_q, state_d;
    logic [2:0]      tw_q, tw_d;
    logic [3:0][3:0] stg_q, stg_d;
    logic [5:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic            set_q, set_d;
    logic [2:0]      start_sync_q, start_sync_d;
    logic [2:0]      next_sync_q, next_sync_d;

    logic            start_edge;
    logic            next_edge;
    logic            key_hit;
    logic            key_lost;
    logic            key_valid;
    logic [3:0]      key_code;
    logic            released;
    logic            abort_key;
    logic            dig_ok;
    logic [7:0]      pre_h;
    logic [7:0]      pre_m;
    logic [6:0]      h7;
    logic [6:0]      m7;

`ifdef KEYPAD_ABORT_EN
    assign abort_key = (key_code == KEY_STAR);
`else
    assign abort_key = 1'b0;
`endif

    assign busy = (state_q != ST_IDLE) && (state_q != ST_COMMIT);

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DB_TICKS (DB_TICKS)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .row       (row),
        .col       (col),
        .key_hit   (key_hit),
        .key_lost  (key_lost),
        .key_valid (key_valid),
        .key_code  (key_code),
        .released  (released)
    );

    always_comb begin
        start_sync_d = {start_sync_q[1:0], start};
        next_sync_d  = {next_sync_q[1:0], next};
        start_edge   = start_sync_q[1] & ~start_sync_q[2];
        next_edge    = next_sync_q[1] & ~next_sync_q[2];
    end

    always_comb begin
        unique case (tw_q)
            3'd0: dig_ok = key_code <= MAX_HT;
            3'd1: dig_ok = key_code <= ((stg_q[0] == MAX_HT) ?
                                        MAX_HO_AT_2 : MAX_HO);
            3'd2: dig_ok = key_code <= MAX_MT;
            3'd3: dig_ok = key_code <= MAX_MO;
            default: dig_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tw_d    = tw_q;
        stg_d   = stg_q;
        hour_d  = hour_q;
        min_d   = min_q;
        set_d   = 1'b0;
        pre_h   = split_dec(hour_q);
        pre_m   = split_dec(min_q);
        h7      = 7'(stg_q[0]) * 7'd10 + 7'(stg_q[1]);
        m7      = 7'(stg_q[2]) * 7'd10 + 7'(stg_q[3]);
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    stg_d[0] = pre_h[7:4];
                    stg_d[1] = pre_h[3:0];
                    stg_d[2] = pre_m[7:4];
                    stg_d[3] = pre_m[3:0];
                    tw_d     = 3'd0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (next_edge) begin
                    tw_d = tw_q + 3'd1;
                    if (tw_q == 3'd3)
                        state_d = ST_COMMIT;
                    else if (key_hit)
                        state_d = ST_DEBOUNCE;
                end else if (key_hit) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (key_valid)
                    state_d = ST_DECODE;
                else if (key_lost)
                    state_d = ST_SCAN;
            end
            ST_DECODE: begin
                state_d = ST_WAIT_REL;
                if (abort_key) begin
                    tw_d    = TW_DONE;
                    state_d = ST_IDLE;
                end else if (dig_ok) begin
                    stg_d[tw_q[1:0]] = key_code;
                    // An hour tens of 2 caps the already staged ones digit.
                    if (tw_q == 3'd0 && key_code == MAX_HT &&
                        stg_q[1] > MAX_HO_AT_2)
                        stg_d[1] = MAX_HO_AT_2;
                    tw_d = tw_q + 3'd1;
                end
            end
            ST_WAIT_REL: begin
                if (released)
                    state_d = (tw_q == TW_DONE) ? ST_COMMIT : ST_SCAN;
            end
            ST_COMMIT: begin
                hour_d  = 6'(h7);
                min_d   = 6'(m7);
                set_d   = 1'b1;
                tw_d    = TW_DONE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tw_q         <= TW_DONE;
            stg_q        <= '0;
            hour_q       <= '0;
            min_q        <= '0;
            set_q        <= 1'b0;
            start_sync_q <= '0;
            next_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            tw_q         <= tw_d;
            stg_q        <= stg_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            set_q        <= set_d;
            start_sync_q <= start_sync_d;
            next_sync_q  <= next_sync_d;
        end
    end

    assign key_hour   = hour_q;
    assign key_minute = min_q;
    assign twinkle    = tw_q;
    assign set_time   = set_q;

endmodule

// File: tb/tb_time_entry_keypad.sv
// Bench for time_entry_keypad: directed vector table, multi-cycle corner
// sequences and random sessions against a digit-level reference model.
module tb_time_entry_keypad;

    localparam int SCAN_DIV = 4;
    localparam int DB_TICKS = 3;
`ifdef KEYPAD_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif
    localparam int ACT_START = 16;
    localparam int ACT_NEXT  = 17;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       next;
    logic [3:0] row;
    logic [3:0] col;
    logic [5:0] key_hour;
    logic [5:0] key_minute;
    logic [2:0] twinkle;
    logic       set_time;
    logic       busy;
    logic [15:0] held;

    int n_chk = 0;
    int n_fail = 0;
    int set_cnt = 0;
    int pos_r[16];
    int pos_c[16];

    typedef struct {
        int act;
        int tw;
        int bsy;
        int hr;
        int mn;
        int sets;
    } vec_t;
    vec_t tbl[$];

    int m_stg[4];
    int m_tw = 4;
    int m_busy = 0;
    int m_hour = 0;
    int m_min = 0;
    int m_sets = 0;

    always #5 clk = ~clk;

    time_entry_keypad #(
        .SCAN_DIV (SCAN_DIV),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .next       (next),
        .row        (row),
        .col        (col),
        .key_hour   (key_hour),
        .key_minute (key_minute),
        .twinkle    (twinkle),
        .set_time   (set_time),
        .busy       (busy)
    );

    // Passive keypad: a held key shorts its row to its driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    always @(posedge clk)
        if (set_time === 1'b1)
            set_cnt <= set_cnt + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int tw, input int bsy,
                           input int hr, input int mn, input int sets);
        chk({tag, " twinkle"}, int'(twinkle), tw);
        chk({tag, " busy"}, int'(busy), bsy);
        chk({tag, " key_hour"}, int'(key_hour), hr);
        chk({tag, " key_minute"}, int'(key_minute), mn);
        chk({tag, " set_count"}, set_cnt, sets);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_tw, m_busy, m_hour, m_min, m_sets);
    endtask

    task automatic press(input int code, input int hold);
        held = '0;
        held[pos_r[code]*4+pos_c[code]] = 1'b1;
        repeat (hold) @(negedge clk);
        held = '0;
        repeat (80) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_next();
        next = 1'b1;
        repeat (8) @(negedge clk);
        next = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_act(input int act);
        if (act == ACT_START)
            pulse_start();
        else if (act == ACT_NEXT)
            pulse_next();
        else
            press(act, 80);
    endtask

    function automatic void m_commit();
        m_hour = 10 * m_stg[0] + m_stg[1];
        m_min  = 10 * m_stg[2] + m_stg[3];
        m_sets++;
        m_tw   = 4;
        m_busy = 0;
    endfunction

    function automatic void m_start();
        if (m_busy == 0) begin
            m_stg[0] = m_hour / 10;
            m_stg[1] = m_hour % 10;
            m_stg[2] = m_min / 10;
            m_stg[3] = m_min % 10;
            m_tw     = 0;
            m_busy   = 1;
        end
    endfunction

    function automatic void m_next();
        if (m_busy != 0) begin
            if (m_tw == 3) begin
                m_tw = 4;
                m_commit();
            end else begin
                m_tw++;
            end
        end
    endfunction

    function automatic void m_key(input int code);
        int lim;
        if (m_busy == 0)
            return;
        if (code == 14 && ABORT_EN) begin
            m_tw   = 4;
            m_busy = 0;
            return;
        end
        if (code > 9)
            return;
        case (m_tw)
            0: lim = 2;
            1: lim = (m_stg[0] == 2) ? 3 : 9;
            2: lim = 5;
            default: lim = 9;
        endcase
        if (code <= lim) begin
            m_stg[m_tw] = code;
            if (m_tw == 0 && code == 2 && m_stg[1] > 3)
                m_stg[1] = 3;
            m_tw++;
            if (m_tw == 4)
                m_commit();
        end
    endfunction

    initial begin
        int k;
        int a;
        pos_r = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
        pos_c = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

        tbl.push_back('{ACT_START, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0});
        tbl.push_back('{2, 2, 1, 0, 0, 0});
        tbl.push_back('{3, 3, 1, 0, 0, 0});
        tbl.push_back('{4, 4, 0, 12, 34, 1});
        tbl.push_back('{ACT_START, 0, 1, 12, 34, 1});
        tbl.push_back('{2, 1, 1, 12, 34, 1});
        tbl.push_back('{7, 1, 1, 12, 34, 1});
        tbl.push_back('{3, 2, 1, 12, 34, 1});
        tbl.push_back('{0, 3, 1, 12, 34, 1});
        tbl.push_back('{0, 4, 0, 23, 0, 2});
        tbl.push_back('{ACT_START, 0, 1, 23, 0, 2});
        tbl.push_back('{1, 1, 1, 23, 0, 2});
        tbl.push_back('{2, 2, 1, 23, 0, 2});
        tbl.push_back('{3, 3, 1, 23, 0, 2});
        tbl.push_back('{4, 4, 0, 12, 34, 3});
        tbl.push_back('{ACT_START, 0, 1, 12, 34, 3});
        tbl.push_back('{0, 1, 1, 12, 34, 3});
        tbl.push_back('{9, 2, 1, 12, 34, 3});
        tbl.push_back('{ACT_NEXT, 3, 1, 12, 34, 3});
        tbl.push_back('{ACT_NEXT, 4, 0, 9, 34, 4});
        tbl.push_back('{ACT_START, 0, 1, 9, 34, 4});
        tbl.push_back('{2, 1, 1, 9, 34, 4});
        tbl.push_back('{ACT_NEXT, 2, 1, 9, 34, 4});
        tbl.push_back('{ACT_NEXT, 3, 1, 9, 34, 4});
        tbl.push_back('{ACT_NEXT, 4, 0, 23, 34, 5});
        tbl.push_back('{15, 4, 0, 23, 34, 5});
        tbl.push_back('{ACT_START, 0, 1, 23, 34, 5});
        tbl.push_back('{ACT_START, 0, 1, 23, 34, 5});
        tbl.push_back('{10, 0, 1, 23, 34, 5});
        tbl.push_back('{15, 0, 1, 23, 34, 5});
        tbl.push_back('{13, 0, 1, 23, 34, 5});
        tbl.push_back('{ACT_NEXT, 1, 1, 23, 34, 5});
        tbl.push_back('{ACT_NEXT, 2, 1, 23, 34, 5});
        tbl.push_back('{ACT_NEXT, 3, 1, 23, 34, 5});
        tbl.push_back('{ACT_NEXT, 4, 0, 23, 34, 6});

        rst   = 1'b0;
        start = 1'b0;
        next  = 1'b0;
        held  = '0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all("reset", 4, 0, 0, 0, 0);
        chk("reset col", int'(col), 15);
        chk("reset set_time", int'(set_time), 0);

        foreach (tbl[i]) begin
            do_act(tbl[i].act);
            chk_all($sformatf("vec%0d", i), tbl[i].tw, tbl[i].bsy,
                    tbl[i].hr, tbl[i].mn, tbl[i].sets);
        end

        // Short bounce on key 1 while its column is driven.
        pulse_start();
        for (k = 0; k < 40 && col[0] !== 1'b0; k++)
            @(negedge clk);
        chk("bounce col wait", int'(k < 40), 1);
        press(1, 6);
        chk_all("bounce", 0, 1, 23, 34, 6);

        // Keys 1 (row 0) and 7 (row 2) share column 0.
        held = '0;
        held[0*4+0] = 1'b1;
        held[2*4+0] = 1'b1;
        repeat (80) @(negedge clk);
        held = '0;
        repeat (80) @(negedge clk);
        chk_all("two rows", 1, 1, 23, 34, 6);
        pulse_next();
        pulse_next();
        pulse_next();
        chk_all("two rows commit", 4, 0, 13, 34, 7);

        pulse_start();
        press(1, 80);
        press(2, 80);
        chk_all("pre reset", 2, 1, 13, 34, 7);
        rst = 1'b0;
        #2;
        chk("async reset twinkle", int'(twinkle), 4);
        repeat (3) @(negedge clk);
        chk_all("in reset", 4, 0, 0, 0, 7);
        chk("in reset col", int'(col), 15);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk_all("after reset", 4, 0, 0, 0, 7);

        m_hour = 0;
        m_min  = 0;
        m_sets = 7;
        m_tw   = 4;
        m_busy = 0;
        for (int s = 0; s < 8; s++) begin
            pulse_start();
            m_start();
            chk_model($sformatf("rnd%0d start", s));
            for (int j = 0; j < 8 && m_busy != 0; j++) begin
                a = int'($urandom_range(0, 19));
                if (a >= 16) begin
                    pulse_next();
                    m_next();
                end else begin
                    press(a, 80);
                    m_key(a);
                end
                chk_model($sformatf("rnd%0d step%0d act%0d", s, j, a));
            end
            for (int j = 0; j < 4 && m_busy != 0; j++) begin
                pulse_next();
                m_next();
                chk_model($sformatf("rnd%0d flush%0d", s, j));
            end
        end

        pulse_start();
        m_start();
        press(1, 80);
        m_key(1);
        press(2, 80);
        m_key(2);
        chk_model("star pre");
        press(14, 80);
        m_key(14);
        chk_model("star");
        for (int j = 0; j < 4 && m_busy != 0; j++) begin
            pulse_next();
            m_next();
            chk_model($sformatf("star flush%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
